// File: rtl/fir_window_feeder.sv
// fir_window_feeder: producer side of the tap-window MAC interface.
// Keeps the newest TAPS samples in a delay line plus a TAPS-entry coefficient
// memory, launches one MAC operation per accepted sample and hands each MAC
// result to a consumer over a valid/ready handshake.
// Optional build macro: FIR_FEEDER_TIMEOUT_EN adds a WAIT-state watchdog that
// substitutes a zero result and raises a sticky timeout_err_o if the MAC never answers.
module fir_window_feeder #(
    parameter int TAPS    = 8,
    parameter int DW      = 16,
    parameter int RW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DW-1:0]           s_data_i,
    input  logic                    coef_we_i,
    input  logic [$clog2(TAPS)-1:0] coef_addr_i,
    input  logic [DW-1:0]           coef_data_i,
    output logic                    coef_err_o,
    output logic [TAPS*DW-1:0]      d_out_o,
    output logic [TAPS*DW-1:0]      cmem_out_o,
    output logic                    mac_start_o,
    input  logic                    mac_done_i,
    input  logic [RW-1:0]           mac_result_i,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    output logic [RW-1:0]           r_data_o,
    output logic                    timeout_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t          state_q;
    logic            s_ready_q;
    logic            coef_err_q;
    logic            mac_start_q;
    logic            r_valid_q;
    logic [RW-1:0]   r_data_q;
    logic [DW-1:0]   win_q  [TAPS];
    logic [DW-1:0]   cmem_q [TAPS];
    logic            accept_s;
    logic            timeout_s;

    // A sample is taken only while idle and advertising readiness.
    assign accept_s = (state_q == ST_IDLE) && s_ready_q && s_valid_i;

`ifdef FIR_FEEDER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tcnt_q;
    logic          timeout_err_q;

    // Fires on the last permitted WAIT cycle; a coincident mac_done still wins.
    assign timeout_s = (state_q == ST_WAIT) && !mac_done_i && (tcnt_q == CW'(TIMEOUT - 1));

    // Watchdog: counts cycles spent in WAIT and latches the sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if (state_q == ST_WAIT) begin
                tcnt_q <= tcnt_q + CW'(1);
            end else begin
                tcnt_q <= '0;
            end
            if (timeout_s) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err_o = timeout_err_q;
`else
    assign timeout_s     = 1'b0;
    assign timeout_err_o = 1'b0;
`endif

    // Control FSM with registered handshake outputs, delay line and coefficient memory.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            s_ready_q   <= 1'b0;
            coef_err_q  <= 1'b0;
            mac_start_q <= 1'b0;
            r_valid_q   <= 1'b0;
            r_data_q    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                win_q[i]  <= '0;
                cmem_q[i] <= '0;
            end
        end else begin
            mac_start_q <= 1'b0;
            // Writes outside IDLE would corrupt an in-flight window: drop and flag them.
            coef_err_q  <= coef_we_i && (state_q != ST_IDLE);
            if (coef_we_i && (state_q == ST_IDLE)) begin
                cmem_q[coef_addr_i] <= coef_data_i;
            end
            case (state_q)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (accept_s) begin
                        for (int i = TAPS - 1; i > 0; i--) begin
                            win_q[i] <= win_q[i-1];
                        end
                        win_q[0]    <= s_data_i;
                        s_ready_q   <= 1'b0;
                        mac_start_q <= 1'b1;
                        state_q     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mac_done_i) begin
                        r_data_q  <= mac_result_i;
                        r_valid_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end else if (timeout_s) begin
                        r_data_q  <= '0;
                        r_valid_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (r_ready_i) begin
                        r_valid_q <= 1'b0;
                        s_ready_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    s_ready_q <= 1'b0;
                    r_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Flatten the window and coefficient memory; element 0 sits in the low bits.
    for (genvar g = 0; g < TAPS; g++) begin : g_pack
        assign d_out_o[g*DW +: DW]    = win_q[g];
        assign cmem_out_o[g*DW +: DW] = cmem_q[g];
    end

    assign s_ready_o   = s_ready_q;
    assign coef_err_o  = coef_err_q;
    assign mac_start_o = mac_start_q;
    assign r_valid_o   = r_valid_q;
    assign r_data_o    = r_data_q;

endmodule

// File: tb/tb_fir_window_feeder.sv
// Self-checking bench for fir_window_feeder: a transaction-level reference
// model is stepped on every rising edge and all outputs are compared 1 time
// unit later; directed sequences add hand-computed literal expectations.
module tb_fir_window_feeder;

    localparam int TAPS    = 8;
    localparam int DW      = 16;
    localparam int RW      = 32;
    localparam int TIMEOUT = 64;
    localparam int AW      = $clog2(TAPS);
    localparam int LAT     = 9;

    logic                 clk;
    logic                 reset;
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_data;
    logic                 coef_we;
    logic [AW-1:0]        coef_addr;
    logic [DW-1:0]        coef_data;
    logic                 coef_err;
    logic [TAPS*DW-1:0]   d_out;
    logic [TAPS*DW-1:0]   cmem_out;
    logic                 mac_start;
    logic                 mac_done;
    logic [RW-1:0]        mac_result;
    logic                 r_valid;
    logic                 r_ready;
    logic [RW-1:0]        r_data;
    logic                 timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    fir_window_feeder #(.TAPS(TAPS), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .coef_we_i(coef_we), .coef_addr_i(coef_addr), .coef_data_i(coef_data),
        .coef_err_o(coef_err), .d_out_o(d_out), .cmem_out_o(cmem_out),
        .mac_start_o(mac_start), .mac_done_i(mac_done), .mac_result_i(mac_result),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_data_o(r_data),
        .timeout_err_o(timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_win  [TAPS];
    logic [DW-1:0] m_cmem [TAPS];
    logic          m_rdy, m_busy, m_start, m_wait, m_rv, m_cerr, m_tout;
    logic [RW-1:0] m_rd, m_exp;
    int            m_tcnt;

    function automatic logic [RW-1:0] model_dot();
        logic [RW-1:0] acc;
        acc = '0;
        for (int i = 0; i < TAPS; i++) acc = acc + RW'(m_win[i]) * RW'(m_cmem[i]);
        return acc;
    endfunction

    function automatic logic [TAPS*DW-1:0] pack(input logic [DW-1:0] a [TAPS]);
        logic [TAPS*DW-1:0] v;
        v = '0;
        for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = a[i];
        return v;
    endfunction

    task automatic model_step();
        logic acc_s, old_busy, old_start, old_wait, old_rv;
        if (reset) begin
            m_rdy = 1'b0; m_busy = 1'b0; m_start = 1'b0; m_wait = 1'b0;
            m_rv = 1'b0; m_cerr = 1'b0; m_tout = 1'b0;
            m_rd = '0; m_exp = '0; m_tcnt = 0;
            for (int i = 0; i < TAPS; i++) begin
                m_win[i] = '0;
                m_cmem[i] = '0;
            end
        end else begin
            old_busy = m_busy; old_start = m_start; old_wait = m_wait; old_rv = m_rv;
            acc_s  = s_valid && m_rdy;
            m_cerr = coef_we && old_busy;
            if (coef_we && !old_busy) m_cmem[coef_addr] = coef_data;
            m_start = acc_s;
            if (acc_s) begin
                for (int i = TAPS - 1; i > 0; i--) m_win[i] = m_win[i-1];
                m_win[0] = s_data;
                m_busy = 1'b1;
                m_rdy  = 1'b0;
                m_exp  = model_dot();
            end else if (!old_busy) begin
                m_rdy = 1'b1;
            end
            if (old_start) begin
                m_wait = 1'b1;
                m_tcnt = 0;
            end
            if (old_wait) begin
                if (mac_done) begin
                    m_wait = 1'b0; m_rv = 1'b1; m_rd = m_exp;
                end
`ifdef FIR_FEEDER_TIMEOUT_EN
                else begin
                    m_tcnt++;
                    if (m_tcnt >= TIMEOUT) begin
                        m_wait = 1'b0; m_rv = 1'b1; m_rd = '0; m_tout = 1'b1;
                    end
                end
`endif
            end
            if (old_rv && r_ready) begin
                m_rv = 1'b0; m_busy = 1'b0; m_rdy = 1'b1;
            end
        end
    endtask

    // Compare process: step the model on each rising edge, check 1 unit later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("s_ready", s_ready, m_rdy);
            chk("mac_start", mac_start, m_start);
            chk("r_valid", r_valid, m_rv);
            if (m_rv || reset) chk("r_data", r_data, m_rd);
            chk("coef_err", coef_err, m_cerr);
            chk("timeout_err", timeout_err, m_tout);
            chk("d_out", d_out, pack(m_win));
            chk("cmem_out", cmem_out, pack(m_cmem));
        end
    end

    // ---------------- MAC stub ----------------
    int            stub_cnt = 0;
    logic [RW-1:0] stub_val;
    bit            stub_en = 1'b1;
    bit            spur_en = 1'b0;

    initial begin
        mac_done   = 1'b0;
        mac_result = '0;
        forever begin
            @(negedge clk);
            mac_done = 1'b0;
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0 && stub_en) begin
                    mac_done   = 1'b1;
                    mac_result = stub_val;
                end
            end else if (spur_en && $urandom_range(0, 15) == 0) begin
                mac_done   = 1'b1;
                mac_result = $urandom;
            end
            if (mac_start === 1'b1) begin
                stub_cnt = LAT;
                stub_val = '0;
                for (int i = 0; i < TAPS; i++)
                    stub_val = stub_val + RW'(d_out[i*DW +: DW]) * RW'(cmem_out[i*DW +: DW]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic launch(input logic [DW-1:0] x, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        int t;
        t = 0;
        while (s_ready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("s_ready_wait", s_ready, 1'b1);
        s_valid = 1'b1; s_data = x;
        coef_we = we; coef_addr = a; coef_data = d;
        @(negedge clk);
        s_valid = 1'b0; coef_we = 1'b0;
    endtask

    task automatic get_result(output logic [RW-1:0] res, output int t);
        t = 0;
        while (r_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("r_valid_seen", r_valid, 1'b1);
        res = r_data;
        @(negedge clk);
    endtask

    task automatic write_coef(input logic [AW-1:0] a, input logic [DW-1:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    logic [RW-1:0] ramp_exp [8];
    logic [RW-1:0] res;
    logic [RW-1:0] held;
    int            lat;

    initial begin
        ramp_exp = '{32'd1, 32'd3, 32'd6, 32'd10, 32'd15, 32'd21, 32'd28, 32'd36};
        reset = 1'b1; s_valid = 1'b0; s_data = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; r_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 1'b0);
        chk("rst_d_out", d_out, '0);
        chk("rst_cmem", cmem_out, '0);
        chk("rst_r_valid", r_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("s_ready_after_reset", s_ready, 1'b1);

        // Ramp: all coefficients 1, samples 1..8.
        for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 16'd1);
        r_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            launch(DW'(k), 1'b0, '0, '0);
            get_result(res, lat);
            chk("ramp_result", res, ramp_exp[k-1]);
        end
        chk("ramp_elem0", d_out[0 +: DW], 16'd8);
        chk("ramp_elem7", d_out[7*DW +: DW], 16'd1);

        // Coefficient write during WAIT is rejected.
        launch(16'd9, 1'b0, '0, '0);
        @(negedge clk);
        write_coef(3'd3, 16'd5);
        chk("coef_err_pulse", coef_err, 1'b1);
        chk("coef_unchanged", cmem_out[3*DW +: DW], 16'd1);
        @(negedge clk);
        chk("coef_err_clear", coef_err, 1'b0);
        get_result(res, lat);
        chk("win9_result", res, 32'd44);

        // Same write in IDLE applies; window 10..3 with c3=5 -> 52 + 4*7.
        write_coef(3'd3, 16'd5);
        chk("coef_applied", cmem_out[3*DW +: DW], 16'd5);
        launch(16'd10, 1'b0, '0, '0);
        get_result(res, lat);
        chk("coef5_result", res, 32'd80);

        // Coefficient write coinciding with a sample: window 11..4, c0=2, c3=5.
        launch(16'd11, 1'b1, 3'd0, 16'd2);
        get_result(res, lat);
        chk("coincident_result", res, 32'd103);

        // Backpressure: r_ready low for 20 cycles while s_valid is asserted.
        r_ready = 1'b0;
        launch(16'd12, 1'b0, '0, '0);
        lat = 0;
        while (r_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        held = r_data;
        chk("bp_result", held, 32'd116);
        for (int c = 0; c < 20; c++) begin
            s_valid = 1'b1; s_data = DW'($urandom);
            @(negedge clk);
            chk("bp_r_valid", r_valid, 1'b1);
            chk("bp_r_data", r_data, held);
            chk("bp_s_ready", s_ready, 1'b0);
        end
        s_valid = 1'b0; r_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_s_ready", s_ready, 1'b1);

        // Reset while waiting on the MAC; the late mac_done must be ignored.
        launch(16'h7FFF, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 1'b0);
        chk("midrst_r_valid", r_valid, 1'b0);
        chk("midrst_d_out", d_out, '0);
        chk("midrst_cmem", cmem_out, '0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("late_done_no_valid", r_valid, 1'b0);
        end

`ifdef FIR_FEEDER_TIMEOUT_EN
        // MAC never answers: zero result, sticky error, then normal operation.
        write_coef(3'd0, 16'd1);
        stub_en = 1'b0;
        launch(16'd5, 1'b0, '0, '0);
        get_result(res, lat);
        chk("timeout_latency", lat >= 64, 1'b1);
        chk("timeout_r_data", res, 32'd0);
        chk("timeout_err_set", timeout_err, 1'b1);
        stub_en = 1'b1;
        launch(16'd3, 1'b0, '0, '0);
        get_result(res, lat);
        chk("after_timeout_result", res, 32'd3);
        chk("timeout_err_sticky", timeout_err, 1'b1);
`endif

        // Randomized traffic with spurious mac_done pulses outside WAIT.
        spur_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            s_valid   = $urandom_range(0, 1) == 1;
            s_data    = DW'($urandom);
            r_ready   = $urandom_range(0, 3) != 0;
            coef_we   = $urandom_range(0, 7) == 0;
            coef_addr = AW'($urandom);
            coef_data = DW'($urandom_range(0, 7));
            @(negedge clk);
        end
        s_valid = 1'b0; coef_we = 1'b0; r_ready = 1'b1; spur_en = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
